// File: rtl/arbiter_rr_pkg.sv
// Shared definitions for the round-robin arbiter.
//   arb_state_e : two-state controller encoding (IDLE / GRANT)
//   arb_clog2   : constant-evaluable ceil(log2) used to size the grant timer
package arbiter_rr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // ceil(log2(value)), with a minimum result of 1 so a counter is never zero-width.
    function automatic int arb_clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/arbiter_rr_decoder.sv
// Index-to-select decoder for the arbiter grant vector.
//   idx_i : SEL_SIZE-bit owner index
//   raw_o : 2**SEL_SIZE-bit select; one-hot (ONE_COLD=0) or one-cold (ONE_COLD=1)
// The arbiter gates this with its valid flag; the decoder itself is purely combinational.
module arbiter_rr_decoder #(
    parameter int SEL_SIZE = 2,
    parameter int ONE_COLD = 0
) (
    input  logic [SEL_SIZE-1:0]        idx_i,
    output logic [(2**SEL_SIZE)-1:0]   raw_o
);

    logic [(2**SEL_SIZE)-1:0] onehot;

    always_comb begin
        onehot        = '0;
        onehot[idx_i] = 1'b1;
        raw_o         = (ONE_COLD != 0) ? ~onehot : onehot;
    end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter sharing one resource among 2**SEL_SIZE requesters.
// A grant is held until the owner strobes done, drops its request, or the grant
// has lasted TMO_CNT cycles; priority then rotates to the requester after the owner.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   req_i  : level-held request vector, bit n = requester n
//   done_i : owner done strobe, only looked at while granting
//   gnt_o  : decoded grant (one-hot / one-cold), inactive pattern when not valid
//   idx_o  : index of current or most recent owner
//   vld_o  : grant active
//   tout_o : one-cycle pulse after a grant was revoked purely by timeout
//
// state    | meaning
// ST_IDLE  | no owner; searches requests from the rotating pointer
// ST_GRANT | idx_q owns the resource; timer counts grant length
module arbiter_rr
    import arbiter_rr_pkg::*;
#(
    parameter int SEL_SIZE = 2,
    parameter int ONE_COLD = 0,
    parameter int TMO_CNT  = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [(2**SEL_SIZE)-1:0]   req_i,
    input  logic                       done_i,
    output logic [(2**SEL_SIZE)-1:0]   gnt_o,
    output logic [SEL_SIZE-1:0]        idx_o,
    output logic                       vld_o,
    output logic                       tout_o
);

    localparam int REQ_SIZE = 2**SEL_SIZE;
    localparam int CNT_W    = arb_clog2(TMO_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CNT - 1);

    arb_state_e           state_q, state_d;
    logic [SEL_SIZE-1:0]  ptr_q,   ptr_d;
    logic [SEL_SIZE-1:0]  idx_q,   idx_d;
    logic                 vld_q,   vld_d;
    logic                 tout_q,  tout_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    logic                 rel_done;
    logic                 rel_drop;
    logic                 rel_tmo;
    logic [REQ_SIZE-1:0]  gnt_raw;

    // First set request at or after ptr, wrapping; index arithmetic wraps
    // naturally in SEL_SIZE bits. Only consulted when req is non-zero.
    function automatic logic [SEL_SIZE-1:0] rr_pick(
        input logic [REQ_SIZE-1:0] req,
        input logic [SEL_SIZE-1:0] ptr
    );
        logic [SEL_SIZE-1:0] cand;
        logic [SEL_SIZE-1:0] pick;
        logic                found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < REQ_SIZE; i++) begin
            cand = ptr + SEL_SIZE'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        rel_done = done_i;
        rel_drop = ~req_i[idx_q];
        rel_tmo  = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_GRANT;
                    idx_d   = rr_pick(req_i, ptr_q);
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (rel_done || rel_drop || rel_tmo) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    // Timeout is reported only when neither done nor a request
                    // drop would have ended the grant on the same cycle.
                    tout_d  = rel_tmo && !rel_done && !rel_drop;
                end
            end

            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    arbiter_rr_decoder #(
        .SEL_SIZE (SEL_SIZE),
        .ONE_COLD (ONE_COLD)
    ) u_decoder (
        .idx_i (idx_q),
        .raw_o (gnt_raw)
    );

    always_comb begin
        if (vld_q) begin
            gnt_o = gnt_raw;
        end else begin
            gnt_o = (ONE_COLD != 0) ? '1 : '0;
        end
    end

    assign idx_o  = idx_q;
    assign vld_o  = vld_q;
    assign tout_o = tout_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr (SEL_SIZE=2, TMO_CNT=4). A one-hot and a one-cold
// instance receive identical stimulus; expected values are written out by hand.
module tb_arbiter_rr;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       tout;

    logic [3:0] gnt_oc;
    logic [1:0] idx_oc;
    logic       vld_oc;
    logic       tout_oc;

    int n_tests = 0;
    int n_fail  = 0;

    arbiter_rr #(.SEL_SIZE(2), .ONE_COLD(0), .TMO_CNT(4)) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .done_i (done),
        .gnt_o  (gnt),
        .idx_o  (idx),
        .vld_o  (vld),
        .tout_o (tout)
    );

    arbiter_rr #(.SEL_SIZE(2), .ONE_COLD(1), .TMO_CNT(4)) u_dut_oc (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .done_i (done),
        .gnt_o  (gnt_oc),
        .idx_o  (idx_oc),
        .vld_o  (vld_oc),
        .tout_o (tout_oc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic v, input logic [1:0] i,
                            input logic [3:0] g, input logic t);
        chk({tag, ".vld"},  {31'd0, vld},  {31'd0, v});
        chk({tag, ".idx"},  {30'd0, idx},  {30'd0, i});
        chk({tag, ".gnt"},  {28'd0, gnt},  {28'd0, g});
        chk({tag, ".tout"}, {31'd0, tout}, {31'd0, t});
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        #2;

        // Reset with every request asserted
        step();
        chk_main("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("reset.oc_gnt", {28'd0, gnt_oc}, 32'hF);
        rst = 1'b0;
        req = 4'b0000;
        step();
        chk_main("idle", 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("idle.oc_gnt", {28'd0, gnt_oc}, 32'hF);

        // Rotation with 1010 held
        req = 4'b1010;
        step();
        chk_main("rot.g1", 1'b1, 2'd1, 4'b0010, 1'b0);
        done = 1'b1;
        step();
        chk_main("rot.rel1", 1'b0, 2'd1, 4'b0000, 1'b0);
        done = 1'b0;
        step();
        chk_main("rot.g3", 1'b1, 2'd3, 4'b1000, 1'b0);
        done = 1'b1;
        step();
        chk_main("rot.rel3", 1'b0, 2'd3, 4'b0000, 1'b0);
        done = 1'b0;
        step();
        chk_main("rot.g1b", 1'b1, 2'd1, 4'b0010, 1'b0);
        done = 1'b1;
        step();
        chk_main("rot.rel1b", 1'b0, 2'd1, 4'b0000, 1'b0);

        // Wrap search: pointer 2, grant 3, release, then only requester 0
        done = 1'b0;
        req  = 4'b1000;
        step();
        chk_main("wrap.g3", 1'b1, 2'd3, 4'b1000, 1'b0);
        done = 1'b1;
        req  = 4'b0001;
        step();
        chk_main("wrap.rel3", 1'b0, 2'd3, 4'b0000, 1'b0);
        done = 1'b0;
        step();
        chk_main("wrap.g0", 1'b1, 2'd0, 4'b0001, 1'b0);
        req = 4'b0000;
        step();
        chk_main("wrap.rel0", 1'b0, 2'd0, 4'b0000, 1'b0);
        // Pointer now 1; only bit 0 requesting forces a full wrap of the search
        req = 4'b0001;
        step();
        chk_main("wrap.g0b", 1'b1, 2'd0, 4'b0001, 1'b0);
        req = 4'b0000;
        step();
        chk_main("wrap.rel0b", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Timeout: grant held exactly 4 cycles, then one-cycle tout
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_main($sformatf("tmo.hold%0d", c), 1'b1, 2'd2, 4'b0100, 1'b0);
        end
        step();
        chk_main("tmo.rel", 1'b0, 2'd2, 4'b0000, 1'b1);
        chk("tmo.oc_tout", {31'd0, tout_oc}, 32'd1);
        // Request still held: new grant of idx2 after the idle cycle, tout clears
        step();
        chk_main("tmo.regrant", 1'b1, 2'd2, 4'b0100, 1'b0);
        step();
        step();
        step();
        chk_main("tmo.c4", 1'b1, 2'd2, 4'b0100, 1'b0);
        done = 1'b1;
        step();
        chk_main("tmo.done_wins", 1'b0, 2'd2, 4'b0000, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        step();
        chk_main("tmo.idle", 1'b0, 2'd2, 4'b0000, 1'b0);

        // Request drop (pointer 3 going in, so idx2 is searched after 3,0,1)
        req = 4'b0100;
        step();
        chk_main("drop.g2", 1'b1, 2'd2, 4'b0100, 1'b0);
        chk("drop.oc_gnt", {28'd0, gnt_oc}, 32'hB);
        req = 4'b1101;
        step();
        chk_main("drop.nopreempt", 1'b1, 2'd2, 4'b0100, 1'b0);
        req = 4'b1001;
        step();
        chk_main("drop.rel", 1'b0, 2'd2, 4'b0000, 1'b0);
        step();
        chk_main("drop.ptr3", 1'b1, 2'd3, 4'b1000, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        step();
        chk_main("drop.rel3", 1'b0, 2'd3, 4'b0000, 1'b0);

        // One-cold instance: grant idx2 then reset mid-grant
        done = 1'b0;
        req  = 4'b0100;
        step();
        chk("oc.g2", {28'd0, gnt_oc}, 32'hB);
        chk("oc.idx", {30'd0, idx_oc}, 32'd2);
        chk("oc.vld", {31'd0, vld_oc}, 32'd1);
        rst = 1'b1;
        step();
        chk("oc.rst_gnt", {28'd0, gnt_oc}, 32'hF);
        chk("oc.rst_vld", {31'd0, vld_oc}, 32'd0);
        chk("oc.rst_idx", {30'd0, idx_oc}, 32'd0);
        chk_main("oc.rst_main", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
